dmem_port_arbiter: RTL and testbench

//  Shares the single-port 256x9 data memory between the core load/store unit
//  (ldr/str) and a debug/loader port used by benches to preload or inspect data.

---
 rtl/dmem_pkg.sv | 35 +++
 rtl/arb_starve_ctr.sv | 29 ++
 rtl/dmem_port_arbiter.sv | 154 +++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory port arbiter.
// Stats counters are enabled by defining DMEM_ARB_STATS_EN.
package dmem_pkg;

    localparam int ADDR_W     = 8;
    localparam int DATA_W     = 9;
    localparam int STARVE_MAX = 4;
    localparam int CNT_W      = 4;
    localparam int STAT_W     = 16;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

    typedef enum logic {
        CORE_PRI,
        DBG_FORCE
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_C,
        OWN_D
    } owner_e;

    function automatic logic [STAT_W-1:0] sat_inc(
        input logic [STAT_W-1:0] v,
        input logic              en
    );
        return (en && (v != '1)) ? v + 1'b1 : v;
    endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// Counts consecutive denied debug-request cycles and flags the
// cycle in which the debug port must be forced next.
module arb_starve_ctr
    import dmem_pkg::*;
#(
    parameter int STARVE_MAX_P = STARVE_MAX
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_denied,
    input  logic i_clear,
    output logic o_hit
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_denied) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_hit = i_denied && (r_cnt == CNT_W'(STARVE_MAX_P - 1));

endmodule

// File: rtl/dmem_port_arbiter.sv
// Core/debug arbiter in front of the single-port data memory.
// Define DMEM_ARB_STATS_EN to add saturating grant/conflict counters.
module dmem_port_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W_P     = ADDR_W,
    parameter int DATA_W_P     = DATA_W,
    parameter int STARVE_MAX_P = STARVE_MAX
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                c_req,
    input  logic                c_we,
    input  logic [ADDR_W_P-1:0] c_addr,
    input  logic [DATA_W_P-1:0] c_wdata,
    output logic                c_gnt,
    output logic                c_rvalid,
    output logic [DATA_W_P-1:0] c_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W_P-1:0] d_addr,
    input  logic [DATA_W_P-1:0] d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W_P-1:0] d_rdata,
`ifdef DMEM_ARB_STATS_EN
    output logic [STAT_W-1:0]   stat_c_cnt,
    output logic [STAT_W-1:0]   stat_d_cnt,
    output logic [STAT_W-1:0]   stat_conflict,
`endif
    output logic                m_en,
    output logic                m_we,
    output logic [ADDR_W_P-1:0] m_addr,
    output logic [DATA_W_P-1:0] m_wdata,
    input  logic [DATA_W_P-1:0] m_rdata
);

    arb_state_e r_state;
    arb_state_e w_state_nxt;
    owner_e     r_owner;
    logic       w_c_gnt;
    logic       w_d_gnt;
    logic       w_hit;
    mem_req_t   w_c_bus;
    mem_req_t   w_d_bus;
    mem_req_t   w_m_bus;

    assign w_c_bus = '{we: c_we, addr: c_addr, wdata: c_wdata};
    assign w_d_bus = '{we: d_we, addr: d_addr, wdata: d_wdata};

    // Grants are decoded from the current state only, so the access
    // happens in the same cycle the request is seen.
    always_comb begin
        w_c_gnt = 1'b0;
        w_d_gnt = 1'b0;
        if (reset_n) begin
            unique case (r_state)
                CORE_PRI: begin
                    if (c_req) begin
                        w_c_gnt = 1'b1;
                    end else if (d_req) begin
                        w_d_gnt = 1'b1;
                    end
                end
                DBG_FORCE: begin
                    w_d_gnt = d_req;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = CORE_PRI;
        if (r_state == CORE_PRI && w_hit) begin
            w_state_nxt = DBG_FORCE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= CORE_PRI;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    arb_starve_ctr #(
        .STARVE_MAX_P (STARVE_MAX_P)
    ) u_starve (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_denied (d_req && !w_d_gnt),
        .i_clear  (!d_req || w_d_gnt),
        .o_hit    (w_hit)
    );

    always_comb begin
        w_m_bus = '0;
        if (w_c_gnt) begin
            w_m_bus = w_c_bus;
        end else if (w_d_gnt) begin
            w_m_bus = w_d_bus;
        end
    end

    assign c_gnt   = w_c_gnt;
    assign d_gnt   = w_d_gnt;
    assign m_en    = w_c_gnt || w_d_gnt;
    assign m_we    = w_m_bus.we;
    assign m_addr  = w_m_bus.addr;
    assign m_wdata = w_m_bus.wdata;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_owner <= OWN_NONE;
        end else if (w_c_gnt && !c_we) begin
            r_owner <= OWN_C;
        end else if (w_d_gnt && !d_we) begin
            r_owner <= OWN_D;
        end else begin
            r_owner <= OWN_NONE;
        end
    end

    // Responses are masked while reset is held so a pending read is dropped.
    assign c_rvalid = reset_n && (r_owner == OWN_C);
    assign d_rvalid = reset_n && (r_owner == OWN_D);
    assign c_rdata  = c_rvalid ? m_rdata : '0;
    assign d_rdata  = d_rvalid ? m_rdata : '0;

`ifdef DMEM_ARB_STATS_EN
    logic [STAT_W-1:0] r_stat_c;
    logic [STAT_W-1:0] r_stat_d;
    logic [STAT_W-1:0] r_stat_x;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_stat_c <= '0;
            r_stat_d <= '0;
            r_stat_x <= '0;
        end else begin
            r_stat_c <= sat_inc(r_stat_c, w_c_gnt);
            r_stat_d <= sat_inc(r_stat_d, w_d_gnt);
            r_stat_x <= sat_inc(r_stat_x, c_req && d_req);
        end
    end

    assign stat_c_cnt    = r_stat_c;
    assign stat_d_cnt    = r_stat_d;
    assign stat_conflict = r_stat_x;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter with a 256x9 synchronous memory.
// Stats checks are compiled in when DMEM_ARB_STATS_EN is defined.
module tb_dmem_port_arbiter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       c_req, c_we, d_req, d_we;
    logic [7:0] c_addr, d_addr, m_addr;
    logic [8:0] c_wdata, d_wdata, m_wdata, m_rdata;
    logic       c_gnt, c_rvalid, d_gnt, d_rvalid;
    logic [8:0] c_rdata, d_rdata;
    logic       m_en, m_we;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0] stat_c_cnt, stat_d_cnt, stat_conflict;
`endif

    dmem_port_arbiter dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .c_req         (c_req),
        .c_we          (c_we),
        .c_addr        (c_addr),
        .c_wdata       (c_wdata),
        .c_gnt         (c_gnt),
        .c_rvalid      (c_rvalid),
        .c_rdata       (c_rdata),
        .d_req         (d_req),
        .d_we          (d_we),
        .d_addr        (d_addr),
        .d_wdata       (d_wdata),
        .d_gnt         (d_gnt),
        .d_rvalid      (d_rvalid),
        .d_rdata       (d_rdata),
`ifdef DMEM_ARB_STATS_EN
        .stat_c_cnt    (stat_c_cnt),
        .stat_d_cnt    (stat_d_cnt),
        .stat_conflict (stat_conflict),
`endif
        .m_en          (m_en),
        .m_we          (m_we),
        .m_addr        (m_addr),
        .m_wdata       (m_wdata),
        .m_rdata       (m_rdata)
    );

    always #5 clk = ~clk;

    logic [8:0] mem [256];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        m_rdata = '0;
    end
    always @(posedge clk) begin
        if (m_en) begin
            if (m_we) mem[m_addr] <= m_wdata;
            else      m_rdata <= mem[m_addr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 0;

    typedef struct {
        int         cyc;
        bit         dport;
        bit         we;
        logic [7:0] addr;
        logic [8:0] data;
    } exp_t;

    exp_t gq[$];
    exp_t rq[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit cr, input bit cw, input logic [7:0] ca,
                         input logic [8:0] cd, input bit dr, input bit dw,
                         input logic [7:0] da, input logic [8:0] dd);
        c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
        d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
    endtask

    task automatic idle();
        drive(0, 0, 8'h00, 9'h000, 0, 0, 8'h00, 9'h000);
    endtask

    task automatic exp_g(input bit dp, input bit we, input logic [7:0] a,
                         input logic [8:0] d);
        exp_t e;
        e.cyc = cyc; e.dport = dp; e.we = we; e.addr = a; e.data = d;
        gq.push_back(e);
    endtask

    task automatic exp_r(input bit dp, input logic [8:0] d);
        exp_t e;
        e.cyc = cyc + 1; e.dport = dp; e.we = 0; e.addr = '0; e.data = d;
        rq.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            while (gq.size() > 0 && gq[0].cyc < cyc) begin
                e = gq.pop_front();
                chk("missed_gnt_cycle", 32'(cyc), 32'(e.cyc));
            end
            while (rq.size() > 0 && rq[0].cyc < cyc) begin
                e = rq.pop_front();
                chk("missed_rvalid_cycle", 32'(cyc), 32'(e.cyc));
            end
            chk("gnt_onehot", 32'(c_gnt & d_gnt), 32'd0);
            if (c_gnt || d_gnt) begin
                if (gq.size() == 0) begin
                    chk("unexpected_gnt", 32'({c_gnt, d_gnt}), 32'd0);
                end else begin
                    e = gq.pop_front();
                    chk("gnt_cycle", 32'(cyc), 32'(e.cyc));
                    chk("gnt_port", 32'(d_gnt), 32'(e.dport));
                    chk("m_en", 32'(m_en), 32'd1);
                    chk("m_we", 32'(m_we), 32'(e.we));
                    chk("m_addr", 32'(m_addr), 32'(e.addr));
                    chk("m_wdata", 32'(m_wdata), 32'(e.data));
                end
            end else begin
                chk("idle_m_bus", 32'({m_en, m_we, m_addr, m_wdata}), 32'd0);
            end
            if (c_rvalid || d_rvalid) begin
                if (rq.size() == 0) begin
                    chk("unexpected_rvalid", 32'({c_rvalid, d_rvalid}), 32'd0);
                end else begin
                    e = rq.pop_front();
                    chk("rvalid_cycle", 32'(cyc), 32'(e.cyc));
                    chk("rvalid_port", 32'({c_rvalid, d_rvalid}),
                        e.dport ? 32'd1 : 32'd2);
                    chk("owner_rdata", 32'(e.dport ? d_rdata : c_rdata),
                        32'(e.data));
                    chk("nonowner_rdata", 32'(e.dport ? c_rdata : d_rdata),
                        32'd0);
                end
            end else begin
                chk("idle_rdata", 32'({c_rdata, d_rdata}), 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        idle();
        step();
        step();
        @(negedge clk);
        chk("rst_gnt", 32'({c_gnt, d_gnt, m_en}), 32'd0);
        chk("rst_rvalid", 32'({c_rvalid, d_rvalid}), 32'd0);
        step();
        reset_n = 1'b1;
        mon_en  = 1'b1;

        // debug write then read-back
        drive(0, 0, 8'h00, 9'h000, 1, 1, 8'h05, 9'h1A5);
        exp_g(1, 1, 8'h05, 9'h1A5);
        step();
        drive(0, 0, 8'h00, 9'h000, 1, 0, 8'h05, 9'h000);
        exp_g(1, 0, 8'h05, 9'h000);
        exp_r(1, 9'h1A5);
        step();
        idle();
        step();

        // continuous contention: C C C C D repeating
        for (int i = 0; i < 10; i++) begin
            drive(1, 1, 8'h30, 9'h011, 1, 0, 8'h05, 9'h000);
            if (i % 5 == 4) begin
                exp_g(1, 0, 8'h05, 9'h000);
                exp_r(1, 9'h1A5);
            end else begin
                exp_g(0, 1, 8'h30, 9'h011);
            end
            step();
        end
        idle();
        step();

        // core str/ldr back-to-back, then read-before-write
        drive(1, 1, 8'h10, 9'h0FF, 0, 0, 8'h00, 9'h000);
        exp_g(0, 1, 8'h10, 9'h0FF);
        step();
        drive(1, 0, 8'h10, 9'h000, 0, 0, 8'h00, 9'h000);
        exp_g(0, 0, 8'h10, 9'h000);
        exp_r(0, 9'h0FF);
        step();
        drive(1, 1, 8'h10, 9'h123, 0, 0, 8'h00, 9'h000);
        exp_g(0, 1, 8'h10, 9'h123);
        step();
        drive(1, 0, 8'h10, 9'h000, 0, 0, 8'h00, 9'h000);
        exp_g(0, 0, 8'h10, 9'h000);
        exp_r(0, 9'h123);
        step();
        idle();
        step();

        // forced debug slot with d_req withdrawn: no access, core stalls
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 8'h31, 9'h022, 1, 0, 8'h05, 9'h000);
            exp_g(0, 1, 8'h31, 9'h022);
            step();
        end
        drive(1, 1, 8'h31, 9'h022, 0, 0, 8'h05, 9'h000);
        step();
        drive(1, 1, 8'h31, 9'h022, 0, 0, 8'h05, 9'h000);
        exp_g(0, 1, 8'h31, 9'h022);
        step();
        idle();
        step();

        // reset right after a read grant drops the response
        drive(1, 0, 8'h10, 9'h000, 0, 0, 8'h00, 9'h000);
        exp_g(0, 0, 8'h10, 9'h000);
        step();
        reset_n = 1'b0;
        drive(1, 1, 8'h20, 9'h1FF, 1, 1, 8'h21, 9'h1FE);
        @(negedge clk);
        chk("rst2_gnt", 32'({c_gnt, d_gnt, m_en}), 32'd0);
        chk("rst2_rvalid", 32'({c_rvalid, d_rvalid}), 32'd0);
        chk("rst2_rdata", 32'({c_rdata, d_rdata}), 32'd0);
        step();
        reset_n = 1'b1;

        // three conflicting cycles straight out of reset
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 8'h40, 9'h0AA, 1, 0, 8'h05, 9'h000);
            exp_g(0, 1, 8'h40, 9'h0AA);
            step();
        end
        idle();
        step();
`ifdef DMEM_ARB_STATS_EN
        chk("stat_conflict", 32'(stat_conflict), 32'd3);
        chk("stat_c_cnt", 32'(stat_c_cnt), 32'd3);
        chk("stat_d_cnt", 32'(stat_d_cnt), 32'd0);
`endif
        step();
        step();
        chk("gnt_queue_empty", 32'(gq.size()), 32'd0);
        chk("rd_queue_empty", 32'(rq.size()), 32'd0);
        mon_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
